ram_browser: RTL
================

RAM_BROWSER -- requirements
Module: ram_browser

Interface
- REQ-001: Parameter DATA_W, default 4: RAM word width and LED width.
- REQ-002: Parameter ADDR_W, default 4: address width; depth is 2**ADDR_W.
- REQ-003: Parameter DEBOUNCE_CYC, default 500000: stable cycles required to accept a key level (10 ms at 50 MHz).
- REQ-004: clk_50  in  1  sole clock; all logic is synchronous to its rising edge.
- REQ-005: rst_n  in  1  asynchronous active-low reset.
- REQ-006: key  in  2  raw push-buttons, active-low; key[0]=step, key[1]=write.
- REQ-007: sw  in  DATA_W  write data, sampled in the WR state.
- REQ-008: led  out  DATA_W  registered read data of the current address.
- REQ-009: addr  out  ADDR_W  current address, registered.
- REQ-010: busy  out  1  high whenever the state is not IDLE.
- REQ-011: err  out  1  sticky write-verify mismatch flag.

Function
- REQ-012: Each key SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DEBOUNCE_CYC consecutive identical synchronized samples.
- REQ-013: A press SHALL be a one-cycle pulse on the debounced high-to-low transition; release produces no pulse.
- REQ-014: RAM SHALL be single-port, 2**ADDR_W x DATA_W, with a registered read (1-cycle latency), inferable as block RAM.
- REQ-015: FSM states SHALL be CLR, IDLE, RD, RD_WAIT, WR, WR_CHK.
- REQ-016: IDLE + step pulse (cycle t) SHALL set addr <= addr+1 and go to RD; RD issues the read; RD_WAIT loads led <= q and returns to IDLE; led is updated at the 3rd edge after t.
- REQ-017: IDLE + write pulse SHALL go to WR; WR writes sw to addr; WR_CHK reads addr, loads led <= q, sets err if q != written value, and returns to IDLE.
- REQ-018: addr SHALL wrap from 2**ADDR_W-1 to 0 with no flag.
- REQ-019: Simultaneous step and write pulses in IDLE SHALL perform the write only; the step is dropped.
- REQ-020: Pulses arriving outside IDLE SHALL be dropped, never queued.
- REQ-021: err SHALL stay set until reset.

Reset
- REQ-022: On rst_n low: addr=0, led=0, err=0, debouncers at released level (1), pulses 0, state = CLR if RAM_BROWSER_CLEAR_EN, else IDLE.
- REQ-023: Reset asserted mid-operation SHALL abort immediately; a RAM write already committed on a prior edge is retained.

Configuration
- REQ-024: With RAM_BROWSER_CLEAR_EN defined, CLR SHALL write 0 to addresses 0..2**ADDR_W-1, one per cycle, with busy=1, then enter IDLE with addr=0; key pulses during CLR are dropped.
- REQ-025: Without RAM_BROWSER_CLEAR_EN, the CLR state and its counter SHALL be absent, and RAM contents are undefined after power-up and unchanged across reset.

Structure
- REQ-026: Package ram_browser_pkg SHALL hold the FSM state enum and the default parameter constants.
- REQ-027: Sub-module key_debounce (synchronizer, debounce counter, press pulse) SHALL be instantiated once per key.

Verification (DEBOUNCE_CYC=4, ADDR_W=4, DATA_W=4)
- REQ-028: Bounce key[0] low/high every 2 cycles for 20 cycles, then release -> no pulse; addr stays 0.
- REQ-029: Write sw=4'hA at addr 0, step, then step 15 more times -> addr returns to 0 and led=4'hA at the 3rd edge after the final pulse.
- REQ-030: Press key[0] and key[1] in the same cycle with sw=4'h5 -> addr unchanged, RAM[addr]=4'h5, led=4'h5, err=0.
- REQ-031: Press step while busy=1 -> press ignored; addr advances exactly once.
- REQ-032: With CLEAR_EN, preload RAM[3]=4'hF, reset -> busy=1 for 16 cycles; stepping to addr 3 gives led=0.
- REQ-033: Assert rst_n in WR_CHK -> next edge after release shows addr=0, led=0, err=0, state IDLE (CLR if CLEAR_EN).

Source files
------------

// File: rtl/ram_browser_pkg.sv
// Shared FSM state type and default parameters for ram_browser.
// Macro RAM_BROWSER_CLEAR_EN adds the power-up/reset RAM clear state.
package ram_browser_pkg;

  localparam int unsigned DATA_W_DEF       = 4;
  localparam int unsigned ADDR_W_DEF       = 4;
  localparam int unsigned DEBOUNCE_CYC_DEF = 500000;

  typedef enum logic [2:0] {
`ifdef RAM_BROWSER_CLEAR_EN
    ST_CLR,
`endif
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_CHK
  } state_e;

endpackage

// File: rtl/ram_browser_key_debounce.sv
// Active-low key conditioner: 2-flop synchronizer, level debouncer, and a
// one-cycle press pulse on the debounced high-to-low transition.
module key_debounce
  import ram_browser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Counter runs only while the synchronized sample disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_d;
  end

  assign press_o = press_q;

endmodule

// File: rtl/ram_browser.sv
// Key-driven RAM browser: step advances and reads, write stores sw and verifies.
// Macro RAM_BROWSER_CLEAR_EN enables zero-fill of the RAM after reset.
module ram_browser
  import ram_browser_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic [1:0]        key,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] led,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              err
);

`ifdef RAM_BROWSER_CLEAR_EN
  localparam state_e RST_STATE = ST_CLR;
  logic [ADDR_W-1:0] clr_q, clr_d;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e            state_q, state_d;
  logic              step_pulse, wr_pulse;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_wd, ram_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (
    .clk_i(clk_50), .rst_ni(rst_n), .key_i(key[0]), .press_o(step_pulse)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_wr (
    .clk_i(clk_50), .rst_ni(rst_n), .key_i(key[1]), .press_o(wr_pulse)
  );

  // Write-first port: the written word appears on q at the write edge, so the
  // verify state can compare it in the following cycle.
  always_ff @(posedge clk_50) begin
    if (ram_we) begin
      mem[ram_a] <= ram_wd;
      ram_q      <= ram_wd;
    end else begin
      ram_q <= mem[ram_a];
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef RAM_BROWSER_CLEAR_EN
      ST_CLR:     if (clr_q == '1) state_d = ST_IDLE;
`endif
      ST_IDLE: begin
        if (wr_pulse)        state_d = ST_WR;
        else if (step_pulse) state_d = ST_RD;
      end
      ST_RD:      state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = ST_IDLE;
      ST_WR:      state_d = ST_WR_CHK;
      ST_WR_CHK:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    ram_we = 1'b0;
    ram_a  = addr_q;
    ram_wd = sw;
    addr_d = addr_q;
    led_d  = led_q;
    err_d  = err_q;
    wdat_d = wdat_q;
`ifdef RAM_BROWSER_CLEAR_EN
    clr_d  = clr_q;
`endif
    case (state_q)
`ifdef RAM_BROWSER_CLEAR_EN
      ST_CLR: begin
        ram_we = 1'b1;
        ram_a  = clr_q;
        ram_wd = '0;
        clr_d  = clr_q + 1'b1;
      end
`endif
      ST_IDLE:    if (!wr_pulse && step_pulse) addr_d = addr_q + 1'b1;
      ST_RD_WAIT: led_d = ram_q;
      ST_WR: begin
        ram_we = 1'b1;
        wdat_d = sw;
      end
      ST_WR_CHK: begin
        led_d = ram_q;
        if (ram_q != wdat_q) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      led_q  <= '0;
      err_q  <= 1'b0;
      wdat_q <= '0;
`ifdef RAM_BROWSER_CLEAR_EN
      clr_q  <= '0;
`endif
    end else begin
      addr_q <= addr_d;
      led_q  <= led_d;
      err_q  <= err_d;
      wdat_q <= wdat_d;
`ifdef RAM_BROWSER_CLEAR_EN
      clr_q  <= clr_d;
`endif
    end
  end

  assign led  = led_q;
  assign addr = addr_q;
  assign err  = err_q;

endmodule
